// File: rtl/tmul_pkg.sv
// Shared types and constants for the tile-multiply row sequencer.
package tmul_pkg;

    localparam int MAX_DIM = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        FP16 = 2'd0,
        BF16 = 2'd1,
        INT8 = 2'd2
    } fmt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        WB    = 2'd3
    } state_t;

endpackage

// File: rtl/tmul_issue_pipe.sv
// Three-stage issue pipeline: S0 strobe in, S1 (load/B read) and S2 (issue) out.
module tmul_issue_pipe
    import tmul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s0_valid,
    input  logic [IDX_W-1:0] s0_k,
    output logic             s1_valid,
    output logic [IDX_W-1:0] s1_k,
    output logic             s2_valid,
    output logic [IDX_W-1:0] s2_k,
    output logic             acc_clear
);

    localparam int NSTG = 2;

    logic             vld_q [NSTG];
    logic             vld_d [NSTG];
    logic [IDX_W-1:0] k_q   [NSTG];
    logic [IDX_W-1:0] k_d   [NSTG];

    always_comb begin
        vld_d[0] = s0_valid;
        k_d[0]   = s0_k;
        for (int i = 1; i < NSTG; i++) begin
            vld_d[i] = vld_q[i-1];
            k_d[i]   = k_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) begin
                vld_q[i] <= 1'b0;
                k_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NSTG; i++) begin
                vld_q[i] <= vld_d[i];
                k_q[i]   <= k_d[i];
            end
        end
    end

    assign s1_valid  = vld_q[0];
    assign s1_k      = k_q[0];
    assign s2_valid  = vld_q[1];
    assign s2_k      = k_q[1];
    assign acc_clear = vld_q[1] && (k_q[1] == '0);

endmodule

// File: rtl/tmul_row_sequencer.sv
// Row sequencer: per output row, streams K operand reads through the issue pipe,
// drains the datapath and hands the row to writeback.
module tmul_row_sequencer #(
    parameter int MAX_DIM  = tmul_pkg::MAX_DIM,
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] cfg_m,
    input  logic [4:0] cfg_k,
    input  logic [1:0] cfg_fmt,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] fmt,
    output logic       a_rd_en,
    output logic [3:0] a_rd_row,
    output logic [3:0] a_rd_col,
    output logic       mult_load,
    output logic       b_rd_en,
    output logic [3:0] b_rd_row,
    output logic       mul_issue,
    output logic       acc_clear,
    output logic       wb_valid,
    output logic [3:0] wb_row,
    input  logic       wb_ready
);
    import tmul_pkg::*;

    // The last mul_issue cycle counts as the first cycle of pipeline latency.
    localparam int         DRAIN_CYC  = (PIPE_LAT > 1) ? PIPE_LAT - 1 : 0;
    localparam logic [3:0] DRAIN_LAST = (DRAIN_CYC > 0) ? 4'(DRAIN_CYC - 1) : 4'd0;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] m_q, m_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] m_last_q, m_last_d;
    logic [IDX_W-1:0] k_last_q, k_last_d;
    fmt_t             fmt_q, fmt_d;
    logic             s0_done_q, s0_done_d;
    logic             gap_q, gap_d;
    logic [3:0]       drain_q, drain_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             s0_valid;
    logic             s1_valid, s2_valid;
    logic [IDX_W-1:0] s1_k, s2_k;
    logic             cfg_legal;

    assign cfg_legal = (cfg_m != 5'd0) && (int'(cfg_m) <= MAX_DIM) &&
                       (cfg_k != 5'd0) && (int'(cfg_k) <= MAX_DIM) &&
                       (cfg_fmt != 2'd3);

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        k_d       = k_q;
        m_last_d  = m_last_q;
        k_last_d  = k_last_q;
        fmt_d     = fmt_q;
        s0_done_d = s0_done_q;
        gap_d     = gap_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        s0_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_legal) begin
                        state_d   = RUN;
                        m_last_d  = 4'(cfg_m - 5'd1);
                        k_last_d  = 4'(cfg_k - 5'd1);
                        fmt_d     = fmt_t'(cfg_fmt);
                        m_d       = '0;
                        k_d       = '0;
                        s0_done_d = 1'b0;
                        gap_d     = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // gap_q gives one quiet cycle between a handshake and the next row's reads.
                gap_d = 1'b0;
                if (!gap_q && !s0_done_q) begin
                    s0_valid = 1'b1;
                    if (k_q == k_last_q) begin
                        s0_done_d = 1'b1;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
                if (s2_valid && (s2_k == k_last_q)) begin
                    drain_d = '0;
                    if (DRAIN_CYC == 0) begin
                        state_d = WB;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = WB;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            WB: begin
                if (wb_ready) begin
                    if (m_q == m_last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = RUN;
                        m_d       = m_q + 4'd1;
                        k_d       = '0;
                        s0_done_d = 1'b0;
                        gap_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            k_q       <= '0;
            m_last_q  <= '0;
            k_last_q  <= '0;
            fmt_q     <= FP16;
            s0_done_q <= 1'b0;
            gap_q     <= 1'b0;
            drain_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            k_q       <= k_d;
            m_last_q  <= m_last_d;
            k_last_q  <= k_last_d;
            fmt_q     <= fmt_d;
            s0_done_q <= s0_done_d;
            gap_q     <= gap_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    tmul_issue_pipe u_pipe (
        .clk       (clk),
        .rst       (rst),
        .s0_valid  (s0_valid),
        .s0_k      (k_q),
        .s1_valid  (s1_valid),
        .s1_k      (s1_k),
        .s2_valid  (s2_valid),
        .s2_k      (s2_k),
        .acc_clear (acc_clear)
    );

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign fmt       = fmt_q;
    assign a_rd_en   = s0_valid;
    assign a_rd_row  = m_q;
    assign a_rd_col  = k_q;
    assign mult_load = s1_valid;
    assign b_rd_en   = s1_valid;
    assign b_rd_row  = s1_k;
    assign mul_issue = s2_valid;
    assign wb_valid  = (state_q == WB);
    assign wb_row    = m_q;

endmodule
